// File: rtl/step_seq_if.sv
// Parent/decoder-side signals of the step initiator. The wired completion lines
// (rdy_, step_rdy_) stay plain nets on the module because they are shared and pulled up.
interface step_seq_if #(
  parameter int SEL_W = 4
);
  localparam int N = 1 << SEL_W;

  logic             ena_;
  logic [SEL_W-1:0] sel;
  logic [N-1:0]     step_ena_;
  logic             busy;
  logic             err;

  modport master (output ena_, sel, input step_ena_, busy, err);
  modport slave  (input ena_, sel, output step_ena_, busy, err);
endinterface

// File: rtl/step_seq.sv
// Step handshake initiator: pulses one unit's enable, waits for a clean low on the
// shared completion line (with a bounded timer) and signals completion on rdy_.
module step_seq #(
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic      clk,
  input  logic      rst_,
  step_seq_if.slave bus,
  output wire       rdy_,
  input  wire       step_rdy_
);
  localparam int N = 1 << SEL_W;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t           state, state_n;
  logic [TO_W-1:0]  cnt, cnt_n;
  logic [SEL_W-1:0] sel_q, sel_n;
  logic             err_q, err_n;
  logic [N-1:0]     step_ena_q, step_ena_n;
  logic             rdy_q, busy_q;
  logic             done_ok;

  // Z or 1 on the pulled-up line must never look like completion.
  assign done_ok = (step_rdy_ == 1'b0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel_q;
    err_n   = err_q;
    case (state)
      IDLE:
        if (!bus.ena_) begin
          state_n = ISSUE;
          sel_n   = bus.sel;
          err_n   = 1'b0;
        end
      ISSUE: begin
        state_n = WAIT;
        cnt_n   = '0;
      end
      WAIT:
        if (done_ok) begin
          state_n = DONE;
          err_n   = 1'b0;
        end else if (cnt == TO_LAST) begin
          state_n = DONE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      DONE:
        if (!bus.ena_) begin
          state_n = ISSUE;
          sel_n   = bus.sel;
          err_n   = 1'b0;
        end else begin
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end

  for (genvar u = 0; u < N; u++) begin : g_unit
    assign step_ena_n[u] = !((state_n == ISSUE) && (sel_n == SEL_W'(u)));
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      cnt        <= '0;
      sel_q      <= '0;
      err_q      <= 1'b0;
      step_ena_q <= '1;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      sel_q      <= sel_n;
      err_q      <= err_n;
      step_ena_q <= step_ena_n;
      rdy_q      <= (state_n == DONE);
      busy_q     <= (state_n == ISSUE) || (state_n == WAIT);
    end
  end

  assign bus.step_ena_ = step_ena_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign rdy_          = rdy_q ? 1'b0 : 1'bz;
endmodule

// File: doc/step_seq.md
# step_seq

Initiator side of the step handshake used by the execution step units. On a launch request it pulses the active-low enable of one selected step unit for one clock, waits for a clean low on the shared, pulled-up completion line, and reports completion upward on its own tristate `rdy_`. A bounded wait timer aborts stalled steps and flags the error. The block sits between instruction decode and the bank of step units.

## Interface

Parameters:
- `SEL_W`, 4: width of `sel`. Number of step units is N = 2^SEL_W.
- `TIMEOUT`, 255: maximum WAIT cycles before abort. Range 1..2^TO_W−1.
- `TO_W`, 8: width of the wait counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_`  in  1  reset, asynchronous, active-low.
- `ena_`  in  1  launch request, active-low, sampled on the rising edge.
- `sel`  in  SEL_W  step unit index, sampled with `ena_`.
- `rdy_`  out  1  completion to parent; driven 0 for one cycle, otherwise Z.
- `step_ena_`  out  N  per-unit enables, active-low; at most one bit low at a time, for exactly one cycle.
- `step_rdy_`  in  1  shared completion line from the step units. It is pulled up. Only a clean 0 counts as done; 1 and Z count as not done.
- `busy`  out  1  high while in ISSUE or WAIT.
- `err`  out  1  timeout flag. Sticky until the next accepted launch.

## Operation

- States: IDLE, ISSUE, WAIT, DONE. State and all outputs are registered.
- IDLE:
  - If `ena_` = 0: latch `sel`, clear `err`, drive `step_ena_[sel]` = 0, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Lasts one cycle; `step_ena_[sel]` is low during it.
  - `step_rdy_` is ignored, because a low here is stale from a previous step.
  - Next: all `step_ena_` bits = 1, counter = 0, go to WAIT.
- WAIT:
  - `step_rdy_` = 0 at the edge: go to DONE, `err` = 0.
  - Else if counter = TIMEOUT−1: go to DONE, `err` = 1.
  - Else: counter +1.
  - If `step_rdy_` = 0 and the timeout hit occur on the same edge, success wins and `err` = 0.
- DONE:
  - Lasts one cycle; `rdy_` is driven 0 during it. This happens for both success and timeout.
  - Next: IDLE, or ISSUE if `ena_` = 0 at this edge (back-to-back launch; the new `sel` is latched and `err` is cleared).
- `ena_` = 0 during ISSUE or WAIT is ignored. There is no restart or queueing, and `err` and `sel` are unaffected.
- The counter never exceeds TIMEOUT−1 and never wraps.
- `sel` outside 0..N−1 is impossible by width.

## Timing

- Reset values (asynchronous, take effect immediately): state IDLE, `step_ena_` all 1, `rdy_` Z, `busy` 0, `err` 0, counter 0, latched sel 0.
- Reset mid-operation: all outputs go to their reset values within the reset assertion, including `step_ena_` and `rdy_` releasing mid-cycle. The first launch is accepted at the first rising edge after `rst_` goes high.
- Launch sampled at edge E0:
  - `step_ena_[sel]` low during E0..E1.
  - WAIT from E1.
  - `busy` high during E0..(DONE entry).
- Completion with `step_rdy_` first low during Ek..Ek+1:
  - Sampled at Ek+1; `rdy_` low during Ek+1..Ek+2; `busy` low from Ek+1.
- Example, a unit that answers two edges after its enable (samples enable at E1, drives `step_rdy_` low during E2..E3):
  - `rdy_` low during E3..E4.
  - Launch-to-completion is 3 cycles.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then DONE with `err` = 1.
- Minimum launch period is 3 cycles (ISSUE, WAIT, DONE) when the step answers on the first WAIT edge.

## Test plan

- Reset: hold `rst_` = 0 for 2 cycles -> `step_ena_` = 16'hFFFF, `rdy_` = Z, `busy` = 0, `err` = 0.
- Nominal launch: `sel` = 5, `ena_` low at E0; step model drives `step_rdy_` = 0 during E2..E3 -> `step_ena_` = 16'hFFDF only during E0..E1; `rdy_` = 0 only during E3..E4; `err` = 0.
- Timeout: TIMEOUT = 4, `sel` = 2, `step_rdy_` held at Z -> `rdy_` = 0 during E5..E6; `err` = 1 from E5 and held; next launch at E8 clears `err`.
- Boundary tie: TIMEOUT = 4, `step_rdy_` = 0 first sampled on the 4th WAIT edge -> `rdy_` pulse, `err` = 0.
- Ignore while busy and stale ready: `ena_` low with `sel` = 9 during WAIT -> no `step_ena_[9]` pulse and the original step completes normally. `step_rdy_` = 0 during ISSUE -> ignored; the block stays in WAIT.
- Back-to-back and reset abort:
  - `ena_` low during DONE with `sel` = 7 -> `step_ena_[7]` low in the very next cycle.
  - `rst_` asserted mid-WAIT -> immediate return to reset values, with no `rdy_` pulse.
